// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the register-file I2C slave.
//   - state_e      : protocol FSM states
//   - START/STOP   : SDA level after the transition that marks each condition
//   - ACK/NACK     : SDA level of the ninth (acknowledge) bit
//   - GC_ADDR_BYTE : general-call address byte
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_PTR      = 4'd3,
        ST_PTR_ACK  = 4'd4,
        ST_WR_DATA  = 4'd5,
        ST_WR_ACK   = 4'd6,
        ST_RD_DATA  = 4'd7,
        ST_RD_MACK  = 4'd8
    } state_e;

    localparam logic START_SDA_LVL = 1'b0;
    localparam logic STOP_SDA_LVL  = 1'b1;
    localparam logic ACK_BIT       = 1'b0;
    localparam logic NACK_BIT      = 1'b1;

    localparam logic [7:0] GC_ADDR_BYTE = 8'h00;

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: oversamples the asynchronous SCL/SDA pins on the system clock.
// Ports:
//   clk_i, rst_i   system clock, synchronous active-high reset
//   scl_i, sda_i   raw bus lines
//   scl_rise/fall  one-cycle pulses on synced SCL edges
//   sda_s          synced SDA level
//   start_det      SDA falls while SCL is high
//   stop_det       SDA rises while SCL is high
module i2c_bus_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_hist_q;
    logic                   sda_hist_q;
    logic                   scl_s;

    // Synchroniser chains plus one history flop; reset to the idle-high bus level
    // so that leaving reset never produces a false edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync_q <= {SYNC_STAGES{1'b1}};
            sda_sync_q <= {SYNC_STAGES{1'b1}};
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
            sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_hist_q;
    assign scl_fall = ~scl_s & scl_hist_q;

    // SCL must be high both before and after the SDA transition.
    assign start_det = scl_s & scl_hist_q & (sda_s != sda_hist_q) & (sda_s == START_SDA_LVL);
    assign stop_det  = scl_s & scl_hist_q & (sda_s != sda_hist_q) & (sda_s == STOP_SDA_LVL);

endmodule

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: fully synchronous I2C slave with a byte register file and
// auto-incrementing pointer. Everything runs on in_clk; SCL/SDA are oversampled.
// Ports:
//   in_clk, in_rst        system clock, synchronous active-high reset
//   in_scl, io_sda        I2C bus (SDA is only ever pulled low or released)
//   out_sda_dir           1 while SDA is pulled low
//   in_host_rd_addr       host read address; out_host_rd_data one cycle later
//   out_wr_strobe/addr/data  one-cycle report of each I2C register write
//   out_busy              addressed transaction in progress
//   out_gen_call          one pulse per general-call data byte
// Build option: define I2C_SLAVE_GENERAL_CALL_EN to ACK the general-call address
// (0x00) and discard its data bytes; otherwise 0x00 is NACKed, out_gen_call is 0.
module i2c_slave_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR        = 7'h50,
    parameter int         NUM_REGS        = 16,
    parameter int         PTR_W           = 8,
    parameter int         SYNC_STAGES     = 2,
    parameter int         SDA_HOLD_CYCLES = 3
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_scl,
    inout  wire              io_sda,
    output logic             out_sda_dir,
    input  logic [PTR_W-1:0] in_host_rd_addr,
    output logic [7:0]       out_host_rd_data,
    output logic             out_wr_strobe,
    output logic [PTR_W-1:0] out_wr_addr,
    output logic [7:0]       out_wr_data,
    output logic             out_busy,
    output logic             out_gen_call
);

`ifdef I2C_SLAVE_GENERAL_CALL_EN
    localparam logic GC_EN = 1'b1;
`else
    localparam logic GC_EN = 1'b0;
`endif

    localparam int               IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [PTR_W:0]   NUM_REGS_X = (PTR_W+1)'(NUM_REGS);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(NUM_REGS - 1);
    localparam logic [PTR_W-1:0] MAX_PTR    = {PTR_W{1'b1}};
    localparam logic [7:0]       HOLD_INIT  = 8'(SDA_HOLD_CYCLES);

    function automatic logic in_range(input logic [PTR_W-1:0] p);
        return ({1'b0, p} < NUM_REGS_X);
    endfunction

    // Wrap at the last register; an out-of-range pointer climbs and saturates.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == LAST_PTR) begin
            n = '0;
        end else if (p == MAX_PTR) begin
            n = MAX_PTR;
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    logic scl_rise_s, scl_fall_s, sda_s, start_s, stop_s;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i    (in_clk),
        .rst_i    (in_rst),
        .scl_i    (in_scl),
        .sda_i    (io_sda),
        .scl_rise (scl_rise_s),
        .scl_fall (scl_fall_s),
        .sda_s    (sda_s),
        .start_det(start_s),
        .stop_det (stop_s)
    );

    state_e           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic             rw_q, rw_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [7:0]       tx_q, tx_d;
    logic             mack_q, mack_d;
    logic             ack_q, ack_d;
    logic             gc_q, gc_d;
    logic             busy_q, busy_d;
    logic             oe_q, oe_d;
    logic [7:0]       hold_q, hold_d;
    logic             strobe_q, strobe_d;
    logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic [7:0]       host_rd_q;
    logic [7:0]       regs_q [NUM_REGS];
    logic             wr_en_s;
    logic             sda_want_s;
    logic [7:0]       ptr_byte_s;

    assign ptr_byte_s = in_range(ptr_q) ? regs_q[ptr_q[IDX_W-1:0]] : 8'hFF;

    // State register, register file and host read port.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= 8'h00;
            bit_cnt_q <= 4'd0;
            rw_q      <= 1'b0;
            ptr_q     <= '0;
            tx_q      <= 8'h00;
            mack_q    <= NACK_BIT;
            ack_q     <= 1'b0;
            gc_q      <= 1'b0;
            busy_q    <= 1'b0;
            oe_q      <= 1'b0;
            hold_q    <= 8'd0;
            strobe_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
            host_rd_q <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            rw_q      <= rw_d;
            ptr_q     <= ptr_d;
            tx_q      <= tx_d;
            mack_q    <= mack_d;
            ack_q     <= ack_d;
            gc_q      <= gc_d;
            busy_q    <= busy_d;
            oe_q      <= oe_d;
            hold_q    <= hold_d;
            strobe_q  <= strobe_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            // Reads the pre-write contents, so a same-cycle collision returns the old byte.
            host_rd_q <= in_range(in_host_rd_addr) ? regs_q[in_host_rd_addr[IDX_W-1:0]] : 8'hFF;
            if (wr_en_s) begin
                regs_q[ptr_q[IDX_W-1:0]] <= shift_q;
            end
        end
    end

    // Next-state logic: bus conditions first, then bit sampling on SCL rise,
    // then byte-level transitions on SCL fall.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        rw_d      = rw_q;
        ptr_d     = ptr_q;
        tx_d      = tx_q;
        mack_d    = mack_q;
        ack_d     = ack_q;
        gc_d      = gc_q;
        busy_d    = busy_q;
        strobe_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_s   = 1'b0;
        if (stop_s) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            gc_d    = 1'b0;
        end else if (start_s) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            gc_d      = 1'b0;
        end else if (scl_rise_s) begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WR_DATA: begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                ST_RD_DATA: begin
                    tx_d      = {tx_q[6:0], 1'b1};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                ST_RD_MACK: mack_d = sda_s;
                default:    mack_d = mack_q;
            endcase
        end else if (scl_fall_s) begin
            case (state_q)
                ST_ADDR: begin
                    if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (shift_q[7:1] == I2C_ADDR) begin
                            state_d = ST_ADDR_ACK;
                            rw_d    = shift_q[0];
                            busy_d  = 1'b1;
                        end else if (GC_EN && (shift_q == GC_ADDR_BYTE)) begin
                            state_d = ST_ADDR_ACK;
                            rw_d    = 1'b0;
                            gc_d    = 1'b1;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    bit_cnt_d = 4'd0;
                    if (rw_q) begin
                        state_d = ST_RD_DATA;
                        tx_d    = ptr_byte_s;
                    end else if (gc_q) begin
                        state_d = ST_WR_DATA;
                    end else begin
                        state_d = ST_PTR;
                    end
                end
                ST_PTR: begin
                    if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        ptr_d     = PTR_W'(shift_q);
                        state_d   = ST_PTR_ACK;
                    end
                end
                ST_PTR_ACK, ST_WR_ACK: begin
                    bit_cnt_d = 4'd0;
                    state_d   = ST_WR_DATA;
                end
                ST_WR_DATA: begin
                    if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        state_d   = ST_WR_ACK;
                        if (gc_q) begin
                            ack_d = 1'b1;
                        end else if (in_range(ptr_q)) begin
                            ack_d     = 1'b1;
                            wr_en_s   = 1'b1;
                            strobe_d  = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = shift_q;
                            ptr_d     = ptr_next(ptr_q);
                        end else begin
                            ack_d = 1'b0;
                            ptr_d = ptr_next(ptr_q);
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        state_d   = ST_RD_MACK;
                        ptr_d     = ptr_next(ptr_q);
                    end
                end
                ST_RD_MACK: begin
                    if (mack_q == ACK_BIT) begin
                        state_d = ST_RD_DATA;
                        tx_d    = ptr_byte_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = state_q;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Desired SDA pull-down for the current bit, applied after the hold delay.
    always_comb begin
        case (state_q)
            ST_ADDR_ACK, ST_PTR_ACK: sda_want_s = 1'b1;
            ST_WR_ACK:               sda_want_s = ack_q;
            ST_RD_DATA:              sda_want_s = ~tx_q[7];
            default:                 sda_want_s = 1'b0;
        endcase
    end

    // Drive timing: release at once on START/STOP, otherwise change the pull-down
    // SDA_HOLD_CYCLES clocks after each synced SCL fall.
    always_comb begin
        oe_d   = oe_q;
        hold_d = hold_q;
        if (start_s || stop_s) begin
            oe_d   = 1'b0;
            hold_d = 8'd0;
        end else if (scl_fall_s) begin
            hold_d = HOLD_INIT;
        end else if (hold_q == 8'd1) begin
            oe_d   = sda_want_s;
            hold_d = 8'd0;
        end else if (hold_q != 8'd0) begin
            hold_d = hold_q - 8'd1;
        end else begin
            hold_d = 8'd0;
        end
    end

`ifdef I2C_SLAVE_GENERAL_CALL_EN
    logic gen_call_q;

    // One pulse per discarded general-call data byte.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            gen_call_q <= 1'b0;
        end else begin
            gen_call_q <= scl_fall_s && !start_s && !stop_s && (state_q == ST_WR_DATA)
                          && gc_q && (bit_cnt_q == 4'd8);
        end
    end

    assign out_gen_call = gen_call_q;
`else
    assign out_gen_call = 1'b0;
`endif

    assign io_sda           = oe_q ? 1'b0 : 1'bz;
    assign out_sda_dir      = oe_q;
    assign out_host_rd_data = host_rd_q;
    assign out_wr_strobe    = strobe_q;
    assign out_wr_addr      = wr_addr_q;
    assign out_wr_data      = wr_data_q;
    assign out_busy         = busy_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
module tb_i2c_slave_regfile;

    localparam int Q = 10;  // clock cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       m_low;
    logic [7:0] host_addr;
    wire        sda_line;
    logic       sda_dir, wr_strobe, busy, gen_call;
    logic [7:0] host_data, wr_addr, wr_data;

    always #5 clk = ~clk;

    assign sda_line = m_low ? 1'b0 : 1'bz;
    pullup (sda_line);

    i2c_slave_regfile dut (
        .in_clk          (clk),
        .in_rst          (rst),
        .in_scl          (scl),
        .io_sda          (sda_line),
        .out_sda_dir     (sda_dir),
        .in_host_rd_addr (host_addr),
        .out_host_rd_data(host_data),
        .out_wr_strobe   (wr_strobe),
        .out_wr_addr     (wr_addr),
        .out_wr_data     (wr_data),
        .out_busy        (busy),
        .out_gen_call    (gen_call)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int strobe_cnt = 0;
    int gc_cnt     = 0;
    int oe_cnt     = 0;
    int busy_cnt   = 0;
    logic [7:0] wa_log[$];
    logic [7:0] wd_log[$];

    // Event monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_strobe) begin
            strobe_cnt++;
            wa_log.push_back(wr_addr);
            wd_log.push_back(wr_data);
        end
        if (gen_call) gc_cnt++;
        if (sda_dir) oe_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        m_low = 1'b0; wait_q();
        scl = 1'b1;   wait_q();
        m_low = 1'b1; wait_q();
        scl = 1'b0;   wait_q();
    endtask

    task automatic bus_stop();
        wait_q();
        m_low = 1'b1; wait_q();
        scl = 1'b1;   wait_q();
        m_low = 1'b0; wait_q();
    endtask

    task automatic send_bit(input logic b);
        wait_q(); m_low = ~b;
        wait_q(); scl = 1'b1;
        wait_q(); wait_q(); scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        wait_q(); m_low = 1'b0;
        wait_q(); scl = 1'b1;
        wait_q(); ack = (sda_line === 1'b0);
        wait_q(); scl = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        wait_q(); m_low = 1'b0;
        wait_q(); scl = 1'b1;
        wait_q(); b = sda_line;
        wait_q(); scl = 1'b0;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        wait_q(); m_low = ~nack;
        wait_q(); scl = 1'b1;
        wait_q(); wait_q(); scl = 1'b0;
    endtask

    task automatic host_read(input logic [7:0] a, output logic [7:0] d);
        host_addr = a;
        @(negedge clk);
        @(negedge clk);
        d = host_data;
    endtask

    logic       ack;
    logic       b;
    logic [7:0] d;
    logic [3:0] nib;
    int         s0, o0, b0, g0;

    initial begin
        rst = 1'b1; scl = 1'b1; m_low = 1'b0; host_addr = 8'h00;
        repeat (4) @(negedge clk);
        check_eq("rst_sda_dir", sda_dir, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_strobe", wr_strobe, 1'b0);
        check_eq("rst_host_data", host_data, 8'h00);
        check_eq("rst_gen_call", gen_call, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Write 0x11, 0x22 starting at register 3.
        s0 = strobe_cnt;
        bus_start();
        write_byte(8'hA0, ack); check_eq("t1_addr_ack", ack, 1'b1);
        check_eq("t1_busy", busy, 1'b1);
        write_byte(8'h03, ack); check_eq("t1_ptr_ack", ack, 1'b1);
        write_byte(8'h11, ack); check_eq("t1_d0_ack", ack, 1'b1);
        write_byte(8'h22, ack); check_eq("t1_d1_ack", ack, 1'b1);
        bus_stop();
        repeat (8) @(negedge clk);
        check_eq("t1_busy_after_stop", busy, 1'b0);
        check_eq("t1_strobes", strobe_cnt - s0, 2);
        check_eq("t1_wa0", wa_log[s0], 8'h03);
        check_eq("t1_wd0", wd_log[s0], 8'h11);
        check_eq("t1_wa1", wa_log[s0+1], 8'h04);
        check_eq("t1_wd1", wd_log[s0+1], 8'h22);
        host_read(8'h04, d); check_eq("t1_host4", d, 8'h22);
        host_read(8'h03, d); check_eq("t1_host3", d, 8'h11);

        // Fill registers 14, 15, 0, 1 across the pointer wrap.
        s0 = strobe_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h0E, ack);
        write_byte(8'h5A, ack); check_eq("t2_d14_ack", ack, 1'b1);
        write_byte(8'hC3, ack);
        write_byte(8'h7E, ack);
        write_byte(8'h99, ack); check_eq("t2_d1_ack", ack, 1'b1);
        bus_stop();
        check_eq("t2_strobes", strobe_cnt - s0, 4);
        check_eq("t2_wrap_addr", wa_log[s0+2], 8'h00);
        check_eq("t2_reg1_addr", wa_log[s0+3], 8'h01);

        // Pointer 0x0E, repeated START, read three bytes with wrap.
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h0E, ack);
        bus_start();
        write_byte(8'hA1, ack); check_eq("t2_rd_addr_ack", ack, 1'b1);
        read_byte(1'b0, d); check_eq("t2_rd_reg14", d, 8'h5A);
        read_byte(1'b0, d); check_eq("t2_rd_reg15", d, 8'hC3);
        read_byte(1'b1, d); check_eq("t2_rd_reg0", d, 8'h7E);
        bus_stop();
        // Pointer must now be 1.
        bus_start();
        write_byte(8'hA1, ack);
        read_byte(1'b1, d); check_eq("t2_ptr_is_1", d, 8'h99);
        bus_stop();

        // Foreign address: no ACK, no drive, not busy, no strobe.
        s0 = strobe_cnt; o0 = oe_cnt; b0 = busy_cnt;
        bus_start();
        write_byte(8'hB0, ack); check_eq("t3_addr_nack", ack, 1'b0);
        check_eq("t3_busy", busy, 1'b0);
        write_byte(8'h01, ack);
        bus_stop();
        check_eq("t3_no_drive", oe_cnt - o0, 0);
        check_eq("t3_never_busy", busy_cnt - b0, 0);
        check_eq("t3_no_strobe", strobe_cnt - s0, 0);

        // Out-of-range pointer.
        s0 = strobe_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h20, ack); check_eq("t4_ptr_ack", ack, 1'b1);
        write_byte(8'h55, ack); check_eq("t4_data_nack", ack, 1'b0);
        bus_stop();
        check_eq("t4_no_strobe", strobe_cnt - s0, 0);
        bus_start();
        write_byte(8'hA1, ack);
        read_byte(1'b1, d); check_eq("t4_read_ff", d, 8'hFF);
        bus_stop();

        // General-call address byte.
        s0 = strobe_cnt; g0 = gc_cnt;
        bus_start();
`ifdef I2C_SLAVE_GENERAL_CALL_EN
        write_byte(8'h00, ack); check_eq("gc_addr_ack", ack, 1'b1);
        write_byte(8'h06, ack); check_eq("gc_data_ack", ack, 1'b1);
        bus_stop();
        check_eq("gc_pulses", gc_cnt - g0, 1);
`else
        write_byte(8'h00, ack); check_eq("gc_addr_nack", ack, 1'b0);
        bus_stop();
        check_eq("gc_no_pulse", gc_cnt - g0, 0);
`endif
        check_eq("gc_no_strobe", strobe_cnt - s0, 0);
        host_read(8'h03, d); check_eq("gc_reg3_kept", d, 8'h11);

        // Reset while driving bit 3 (a 0) of register 3 = 0x11.
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h03, ack);
        bus_start();
        write_byte(8'hA1, ack);
        for (int i = 3; i >= 0; i--) begin
            read_bit(b);
            nib[i] = b;
        end
        check_eq("t5_high_nibble", nib, 4'h1);
        wait_q(); m_low = 1'b0;
        wait_q(); scl = 1'b1;
        wait_q();
        check_eq("t5_driving_bit3", sda_dir, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t5_released", sda_dir, 1'b0);
        check_eq("t5_line_high", sda_line, 1'b1);
        check_eq("t5_busy_clr", busy, 1'b0);
        wait_q(); scl = 1'b0;
        bus_stop();
        bus_start();
        write_byte(8'hA0, ack); check_eq("t5_post_addr_ack", ack, 1'b1);
        write_byte(8'h03, ack);
        bus_start();
        write_byte(8'hA1, ack);
        read_byte(1'b1, d); check_eq("t5_reg3_cleared", d, 8'h00);
        bus_stop();
        host_read(8'h04, d); check_eq("t5_host4_cleared", d, 8'h00);
        host_read(8'h0E, d); check_eq("t5_host14_cleared", d, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
